// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: one shared datapath walks every oscillator once per sample tick.
// Optional per-oscillator square pulse width is enabled by defining OSC_BANK_PW_EN.
module osc_bank #(
  parameter int N_OSC      = 64,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic                       i_clk48,
  input  logic                       i_rst48,
  input  logic [$clog2(N_OSC)-1:0]   i_cfg_osc,
  input  logic [PHASE_W-1:0]         i_cfg_step,
  input  logic                       i_cfg_step_valid,
  input  logic [1:0]                 i_cfg_wav,
  input  logic                       i_cfg_wav_valid,
`ifdef OSC_BANK_PW_EN
  input  logic [7:0]                 i_cfg_pw,
  input  logic                       i_cfg_pw_valid,
`endif
  input  logic                       i_sync,
  input  logic                       i_ready,
  output logic [15:0]                o_sample,
  output logic                       o_valid,
  output logic                       o_overrun
);
  localparam int IDX_W = $clog2(N_OSC);
  localparam int SUM_W = 16 + IDX_W;
  localparam int CNT_W = IDX_W + 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  logic [PHASE_W-1:0] phase_mem [N_OSC];
  logic [PHASE_W-1:0] step_mem  [N_OSC];
  logic [1:0]         wav_mem   [N_OSC];
`ifdef OSC_BANK_PW_EN
  logic [7:0]         pw_mem    [N_OSC];
  logic [7:0]         s1_pw_reg;
`endif

  logic [DIV_W-1:0]   div_reg;
  logic               tick;
  logic               rd_busy_reg;
  logic [IDX_W-1:0]   rd_idx_reg;
  logic               pass_sync_reg;
  logic               sync_pending_reg;

  logic               s1_valid_reg, s1_last_reg, s1_sync_reg;
  logic [IDX_W-1:0]   s1_idx_reg;
  logic [PHASE_W-1:0] s1_phase_reg, s1_step_reg;
  logic [1:0]         s1_wav_reg;

  logic               s2_valid_reg, s2_last_reg, s2_active_reg;
  logic [15:0]        s2_contrib_reg;

  logic signed [SUM_W-1:0] acc_reg;
  logic [CNT_W-1:0]        act_reg;

  assign tick = (div_reg == DIV_W'(SAMPLE_DIV - 1));

  // Tick counter, pass sequencing, overrun and sync bookkeeping
  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      div_reg          <= '0;
      rd_busy_reg      <= 1'b0;
      rd_idx_reg       <= '0;
      pass_sync_reg    <= 1'b0;
      sync_pending_reg <= 1'b0;
      o_overrun        <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      div_reg   <= tick ? '0 : div_reg + DIV_W'(1);
      if (i_sync)
        sync_pending_reg <= 1'b1;
      if (tick) begin
        if (o_valid && !i_ready) begin
          o_overrun <= 1'b1;
        end else begin
          rd_busy_reg      <= 1'b1;
          rd_idx_reg       <= '0;
          pass_sync_reg    <= sync_pending_reg;
          // A sync landing on the tick itself belongs to the following pass
          sync_pending_reg <= i_sync;
        end
      end else if (rd_busy_reg) begin
        rd_idx_reg <= rd_idx_reg + IDX_W'(1);
        if (rd_idx_reg == IDX_W'(N_OSC - 1))
          rd_busy_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      for (int i = 0; i < N_OSC; i++) begin
        step_mem[i] <= '0;
        wav_mem[i]  <= '0;
`ifdef OSC_BANK_PW_EN
        pw_mem[i]   <= 8'h80;
`endif
      end
    end else begin
      if (i_cfg_step_valid)
        step_mem[i_cfg_osc] <= i_cfg_step;
      if (i_cfg_wav_valid)
        wav_mem[i_cfg_osc] <= i_cfg_wav;
`ifdef OSC_BANK_PW_EN
      if (i_cfg_pw_valid)
        pw_mem[i_cfg_osc] <= i_cfg_pw;
`endif
    end
  end

  // Registered read; a same-cycle config write is seen on the next pass
  always_ff @(posedge i_clk48) begin
    if (i_rst48)
      s1_valid_reg <= 1'b0;
    else
      s1_valid_reg <= rd_busy_reg;
    s1_idx_reg   <= rd_idx_reg;
    s1_last_reg  <= (rd_idx_reg == IDX_W'(N_OSC - 1));
    s1_sync_reg  <= pass_sync_reg;
    s1_phase_reg <= phase_mem[rd_idx_reg];
    s1_step_reg  <= step_mem[rd_idx_reg];
    s1_wav_reg   <= wav_mem[rd_idx_reg];
`ifdef OSC_BANK_PW_EN
    s1_pw_reg    <= pw_mem[rd_idx_reg];
`endif
  end

  logic        s1_muted;
  logic [15:0] p, wave, contrib;
  logic [14:0] tri_mag;
  logic        square_hi;

  always_comb begin
    s1_muted = (s1_step_reg == '0);
    p        = s1_sync_reg ? 16'h0000 : s1_phase_reg[PHASE_W-1 -: 16];
    tri_mag  = p[15] ? ~p[14:0] : p[14:0];
`ifdef OSC_BANK_PW_EN
    square_hi = (p[15:8] < s1_pw_reg);
`else
    square_hi = ~p[15];
`endif
    wave = 16'h0000;
    case (s1_wav_reg)
      2'd0:    wave = p ^ 16'h8000;
      2'd1:    wave = square_hi ? 16'h7FFF : 16'h8000;
      2'd2:    wave = {tri_mag, 1'b0} ^ 16'h8000;
      default: wave = 16'h0000;
    endcase
    contrib = s1_muted ? 16'h0000 : wave;
  end

  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      for (int i = 0; i < N_OSC; i++)
        phase_mem[i] <= '0;
    end else if (s1_valid_reg && (s1_sync_reg || !s1_muted)) begin
      phase_mem[s1_idx_reg] <= s1_sync_reg ? s1_step_reg : s1_phase_reg + s1_step_reg;
    end
  end

  function automatic logic [CNT_W-1:0] shift_for(input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < CNT_W; i++)
      if ((CNT_W'(1) << i) < n)
        s = CNT_W'(i + 1);
    return s;
  endfunction

  logic signed [SUM_W-1:0] acc_next;
  logic [CNT_W-1:0]        act_next;
  logic [15:0]             mix_out;

  always_comb begin
    acc_next = acc_reg + {{IDX_W{s2_contrib_reg[15]}}, s2_contrib_reg};
    act_next = act_reg + CNT_W'(s2_active_reg);
    mix_out  = 16'(acc_next >>> shift_for(act_next));
  end

  // Mixer accumulate and output handshake
  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      s2_valid_reg   <= 1'b0;
      s2_last_reg    <= 1'b0;
      s2_active_reg  <= 1'b0;
      s2_contrib_reg <= '0;
      acc_reg        <= '0;
      act_reg        <= '0;
      o_sample       <= '0;
      o_valid        <= 1'b0;
    end else begin
      s2_valid_reg   <= s1_valid_reg;
      s2_last_reg    <= s1_valid_reg && s1_last_reg;
      s2_active_reg  <= !s1_muted;
      s2_contrib_reg <= contrib;
      if (o_valid && i_ready)
        o_valid <= 1'b0;
      if (s2_valid_reg) begin
        if (s2_last_reg) begin
          o_sample <= mix_out;
          o_valid  <= 1'b1;
          acc_reg  <= '0;
          act_reg  <= '0;
        end else begin
          acc_reg  <= acc_next;
          act_reg  <= act_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_osc_bank.sv
// Table-driven scoreboard bench for osc_bank (N_OSC=4, PHASE_W=24, SAMPLE_DIV=16).
module tb_osc_bank;
  localparam int N_OSC = 4;
  localparam int PHASE_W = 24;
  localparam int SAMPLE_DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  cfg_osc = '0;
  logic [23:0] cfg_step = '0;
  logic        cfg_step_valid = 1'b0;
  logic [1:0]  cfg_wav = '0;
  logic        cfg_wav_valid = 1'b0;
`ifdef OSC_BANK_PW_EN
  logic [7:0]  cfg_pw = 8'h80;
  logic        cfg_pw_valid = 1'b0;
`endif
  logic        sync = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] sample;
  logic        valid;
  logic        overrun;

  always #5 clk = ~clk;

  osc_bank #(.N_OSC(N_OSC), .PHASE_W(PHASE_W), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .i_clk48(clk), .i_rst48(rst),
    .i_cfg_osc(cfg_osc), .i_cfg_step(cfg_step), .i_cfg_step_valid(cfg_step_valid),
    .i_cfg_wav(cfg_wav), .i_cfg_wav_valid(cfg_wav_valid),
`ifdef OSC_BANK_PW_EN
    .i_cfg_pw(cfg_pw), .i_cfg_pw_valid(cfg_pw_valid),
`endif
    .i_sync(sync), .i_ready(ready),
    .o_sample(sample), .o_valid(valid), .o_overrun(overrun)
  );

  typedef struct packed {
    logic [23:0]      step0;
    logic [1:0]       wav0;
    logic [23:0]      step1;
    logic [1:0]       wav1;
    logic [23:0]      step2;
    logic [1:0]       wav2;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tb_div = 0;
  int last_tick = -1000;
  int overruns = 0;
  bit prev_valid = 1'b0;

  // Independent sample-tick reference used for latency checks
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) tb_div <= 0;
    else     tb_div <= (tb_div == SAMPLE_DIV - 1) ? 0 : tb_div + 1;
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (tb_div == SAMPLE_DIV - 1) last_tick = cyc;
    if (valid && !prev_valid) begin
      checks++;
      if (cyc - last_tick != N_OSC + 3) begin
        errors++;
        $display("FAIL valid_latency: got %0d cycles after tick, expected %0d", cyc - last_tick, N_OSC + 3);
      end
    end
    if (overrun) overruns++;
    if (valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got %h, expected no output", sample);
      end else begin
        e = exp_q.pop_front();
        if (sample !== e) begin
          errors++;
          $display("FAIL sample: got %h, expected %h (cycle %0d)", sample, e, cyc);
        end else begin
          $display("sample %h expected %h ok (cycle %0d)", sample, e, cyc);
        end
      end
    end
    prev_valid = valid;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; cfg_step_valid = 1'b0; cfg_wav_valid = 1'b0; sync = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [23:0] step, input logic [1:0] wav);
    cfg_osc = idx; cfg_step = step; cfg_wav = wav;
    cfg_step_valid = 1'b1; cfg_wav_valid = 1'b1;
    @(posedge clk); #1;
    cfg_step_valid = 1'b0; cfg_wav_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d samples outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_queue(input int left, input int budget);
    for (int i = 0; i < budget && exp_q.size() > left; i++) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [23:0] s0, input logic [1:0] w0,
                              input logic [23:0] s1, input logic [1:0] w1,
                              input logic [23:0] s2, input logic [1:0] w2,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
    vec_t v;
    v.step0 = s0; v.wav0 = w0; v.step1 = s1; v.wav1 = w1; v.step2 = s2; v.wav2 = w2;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  initial begin
    bit seen_valid;
    vecs[0] = mk(24'h400000, 2'd0, 24'h0, 2'd0, 24'h0, 2'd0, 16'h8000, 16'hC000, 16'h0000, 16'h4000);
    vecs[1] = mk(24'h400000, 2'd1, 24'h400000, 2'd1, 24'h0, 2'd0, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000);
    vecs[2] = mk(24'h400000, 2'd2, 24'h0, 2'd0, 24'h0, 2'd0, 16'h8000, 16'h0000, 16'h7FFE, 16'hFFFE);
    vecs[3] = mk(24'h0, 2'd0, 24'h0, 2'd1, 24'h0, 2'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[4] = mk(24'h400000, 2'd0, 24'h400000, 2'd3, 24'h0, 2'd0, 16'hC000, 16'hE000, 16'h0000, 16'h2000);
    vecs[5] = mk(24'h400000, 2'd0, 24'h800000, 2'd0, 24'h0, 2'd0, 16'h8000, 16'hE000, 16'hC000, 16'h2000);
    vecs[6] = mk(24'h400000, 2'd0, 24'h400000, 2'd0, 24'h400000, 2'd0, 16'hA000, 16'hD000, 16'h0000, 16'h3000);

    do_reset();
    @(negedge clk);
    checks += 3;
    if (sample !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h, expected 0000", sample); end
    if (valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid); end
    if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end

    for (int v = 0; v < 7; v++) begin
      do_reset();
      cfg(2'd0, vecs[v].step0, vecs[v].wav0);
      cfg(2'd1, vecs[v].step1, vecs[v].wav1);
      cfg(2'd2, vecs[v].step2, vecs[v].wav2);
      for (int k = 0; k < 4; k++) exp_q.push_back(vecs[v].exp[k]);
      drain(200);
    end

    // Back-pressure across a tick: one dropped tick, phases not advanced
    do_reset();
    cfg(2'd0, 24'h400000, 2'd0);
    ready = 1'b0;
    overruns = 0;
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'hC000);
    repeat (40) @(posedge clk);
    #1;
    checks += 3;
    if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, expected 1", valid); end
    if (sample !== 16'h8000) begin errors++; $display("FAIL stall_hold: got %h, expected 8000", sample); end
    if (overruns != 1) begin errors++; $display("FAIL overrun_count: got %0d, expected 1", overruns); end
    ready = 1'b1;
    drain(100);
    checks++;
    if (overruns != 1) begin errors++; $display("FAIL overrun_after: got %0d, expected 1", overruns); end

    // Hard sync after the third sample restarts the sequence
    do_reset();
    cfg(2'd0, 24'h400000, 2'd0);
    exp_q.push_back(16'h8000); exp_q.push_back(16'hC000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h8000); exp_q.push_back(16'hC000);
    wait_queue(2, 200);
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    drain(200);

    // Reset mid-pass: aborted pass emits nothing, wav/step/phase return to defaults
    do_reset();
    cfg(2'd0, 24'h400000, 2'd1);
    repeat (16) @(posedge clk);
    do_reset();
    cfg(2'd0, 24'h400000, 2'd3);
    cfg_osc = 2'd0; cfg_step = 24'h400000; cfg_step_valid = 1'b1;
    @(posedge clk); #1;
    cfg_step_valid = 1'b0;
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin errors++; $display("FAIL abort_valid: got 1, expected 0"); end
    #1;
    do_reset();
    cfg_osc = 2'd0; cfg_step = 24'h400000; cfg_step_valid = 1'b1;
    @(posedge clk); #1;
    cfg_step_valid = 1'b0;
    exp_q.push_back(16'h8000);
    drain(100);

`ifdef OSC_BANK_PW_EN
    do_reset();
    cfg_pw = 8'h40; cfg_pw_valid = 1'b1;
    cfg(2'd0, 24'h400000, 2'd1);
    cfg_pw_valid = 1'b0;
    exp_q.push_back(16'h7FFF); exp_q.push_back(16'h8000);
    exp_q.push_back(16'h8000); exp_q.push_back(16'h8000);
    drain(200);
`endif

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/osc_bank.md
OSC_BANK -- requirements
Module: osc_bank

Interface
REQ-001 The block SHALL have parameter N_OSC, default 64, giving the number of oscillators (power of 2, 2..64).
REQ-002 The block SHALL have parameter PHASE_W, default 24, giving the phase accumulator width (16..32).
REQ-003 The block SHALL have parameter SAMPLE_DIV, default 1000, giving clock cycles per output sample (at least N_OSC+8).
REQ-004 The block SHALL have port i_clk48, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port i_rst48, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_cfg_osc, input, $clog2(N_OSC) bits: oscillator index for configuration writes.
REQ-007 The block SHALL have port i_cfg_step, input, PHASE_W bits: phase increment per sample; 0 mutes the oscillator.
REQ-008 The block SHALL have port i_cfg_step_valid, input, 1 bit: write strobe for i_cfg_step.
REQ-009 The block SHALL have port i_cfg_wav, input, 2 bits: waveform select (0 saw, 1 square, 2 triangle, 3 silent).
REQ-010 The block SHALL have port i_cfg_wav_valid, input, 1 bit: write strobe for i_cfg_wav.
REQ-011 The block SHALL have port i_sync, input, 1 bit: hard-sync pulse that resets all phases.
REQ-012 The block SHALL have port i_ready, input, 1 bit: the sink accepts o_sample.
REQ-013 The block SHALL have port o_sample, output, 16 bits: signed mixed sample.
REQ-014 The block SHALL have port o_valid, output, 1 bit: o_sample is valid.
REQ-015 The block SHALL have port o_overrun, output, 1 bit: 1-cycle pulse when a sample tick is dropped.

Function
REQ-016 A tick counter SHALL count 0..SAMPLE_DIV-1 and wrap; a tick occurs in the cycle where the count equals SAMPLE_DIV-1.
REQ-017 On a tick with o_valid=0, the block SHALL start one pass: a time-multiplexed pipeline visiting oscillators 0..N_OSC-1, one per cycle, with per-oscillator state held in indexed storage (no per-oscillator adders).
REQ-018 On a tick with o_valid=1 and i_ready=0, the block SHALL skip the pass, leave phases unchanged, and pulse o_overrun for 1 cycle.
REQ-019 Per visited oscillator k, the block SHALL compute the sample from the current phase and then store phase+step modulo 2^PHASE_W.
REQ-020 p SHALL be phase[PHASE_W-1:PHASE_W-16]; saw = p XOR 0x8000; square = 0x7FFF when p[15]=0, else 0x8000; triangle = ((p[15] ? ~p[14:0] : p[14:0]) << 1) XOR 0x8000; silent = 0.
REQ-021 An oscillator with step=0 SHALL contribute 0, SHALL NOT be counted as active, and its phase SHALL hold.
REQ-022 Contributions SHALL be summed sign-extended in 16+$clog2(N_OSC) bits; the result SHALL be arithmetically shifted right by ceil(log2(active count)), with shift 0 for 0 or 1 active; o_sample SHALL be the low 16 bits.
REQ-023 o_valid SHALL assert exactly N_OSC+3 cycles after the tick cycle; o_sample SHALL hold stable while o_valid=1 and i_ready=0; o_valid SHALL clear in the cycle after o_valid=1 and i_ready=1.
REQ-024 A config write in cycle c to oscillator k SHALL affect the current pass only if k is read after cycle c; otherwise it SHALL take effect on the next pass.
REQ-025 Simultaneous step and wav strobes SHALL both be applied.
REQ-026 i_sync SHALL set a pending flag; the next pass SHALL use phase 0 for every oscillator, store phase = step, then clear the flag.
REQ-027 An i_sync arriving during a pass SHALL apply to the following pass.

Reset
REQ-028 Reset SHALL set all phases to 0, steps to 0, wav to 0 (saw), pw to 0x80, tick counter to 0, and clear the pipeline and sync flag.
REQ-029 Reset SHALL set o_sample=0, o_valid=0, o_overrun=0, abort any in-flight pass, and emit no output for it.

Configuration
REQ-030 With macro OSC_BANK_PW_EN defined, ports i_cfg_pw (input, 8 bits) and i_cfg_pw_valid (input, 1 bit) SHALL exist, and square SHALL be 0x7FFF when p[15:8] < pw, else 0x8000.
REQ-031 Without OSC_BANK_PW_EN, those ports and the pw storage SHALL be absent, and square SHALL behave per REQ-020.

Verification (N_OSC=4, PHASE_W=24, SAMPLE_DIV=16, i_ready=1 unless stated)
REQ-032 Bench SHALL cover: osc0 step=0x400000, saw, others muted -> o_sample sequence 0x8000, 0xC000, 0x0000, 0x4000, repeating; o_valid 7 cycles after each tick.
REQ-033 Bench SHALL cover: osc0 and osc1 square, step=0x400000 -> first sample (0x7FFF+0x7FFF)>>1 = 0x7FFF, third sample 0x8000.
REQ-034 Bench SHALL cover: i_ready=0 across two ticks -> o_sample held, o_overrun pulses once; after i_ready=1, the next sample continues the unadvanced sequence.
REQ-035 Bench SHALL cover: i_sync after third saw sample -> next sample 0x8000, then 0xC000.
REQ-036 Bench SHALL cover: all steps 0 -> o_valid pulses every 16 cycles with o_sample=0x0000.
REQ-037 Bench SHALL cover, with OSC_BANK_PW_EN: pw=0x40, square, step=0x400000 -> 0x7FFF, 0x8000, 0x8000, 0x8000 repeating; i_rst48 mid-pass -> o_valid stays 0 and the next output is 0x8000.
